// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter shared by an instruction-fetch and a data requester.
// Data wins contention until an instruction fetch has waited STARVE_MAX data grants.
module unified_mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic [31:0] m_addr,
    output logic [3:0]  m_we,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_I    = 2'd1,
        R_D    = 2'd2
    } resp_state_t;

    resp_state_t   resp_state_r;
    resp_state_t   resp_state_s;
    logic [SW-1:0] streak_r;
    logic [SW-1:0] streak_s;
    logic          i_gnt_s;
    logic          d_gnt_s;

    // Grant selection; grants are forced low while reset is held so memory stays idle.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!reset) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (i_req && (!d_req || (streak_r == STREAK_MAX))) begin
            i_gnt_s = 1'b1;
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Memory-side mux from the granted requester; idle bus is all zeros.
    always_comb begin
        m_addr  = 32'h0000_0000;
        m_we    = 4'b0000;
        m_wdata = 32'h0000_0000;
        case ({i_gnt_s, d_gnt_s})
            2'b10: begin
                m_addr  = {i_addr[31:2], 2'b00};
                m_we    = 4'b0000;
                m_wdata = 32'h0000_0000;
            end
            2'b01: begin
                m_addr  = {d_addr[31:2], 2'b00};
                m_we    = d_we;
                m_wdata = d_wdata;
            end
            default: begin
                m_addr  = 32'h0000_0000;
                m_we    = 4'b0000;
                m_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Streak counts data wins over a waiting fetch; it only survives while the fetch keeps waiting.
    always_comb begin
        streak_s = streak_r;
        if (!i_req || i_gnt_s) begin
            streak_s = {SW{1'b0}};
        end else if (d_gnt_s && (streak_r != STREAK_MAX)) begin
            streak_s = streak_r + SW'(1);
        end else begin
            streak_s = streak_r;
        end
    end

    // Next response state: which requester owns next cycle's m_rdata.
    always_comb begin
        resp_state_s = R_NONE;
        if (i_gnt_s) begin
            resp_state_s = R_I;
        end else if (d_gnt_s && (d_we == 4'b0000)) begin
            resp_state_s = R_D;
        end else begin
            resp_state_s = R_NONE;
        end
    end

    // State registers; reset drops any pending response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_state_r <= R_NONE;
            streak_r     <= {SW{1'b0}};
        end else begin
            resp_state_r <= resp_state_s;
            streak_r     <= streak_s;
        end
    end

    // Read data is steered straight from memory to the owner of the pending response.
    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = 32'h0000_0000;
        d_rvalid = 1'b0;
        d_rdata  = 32'h0000_0000;
        case (resp_state_r)
            R_I: begin
                i_rvalid = 1'b1;
                i_rdata  = m_rdata;
            end
            R_D: begin
                d_rvalid = 1'b1;
                d_rdata  = m_rdata;
            end
            default: begin
                i_rvalid = 1'b0;
                d_rvalid = 1'b0;
            end
        endcase
    end

    assign i_gnt = i_gnt_s;
    assign d_gnt = d_gnt_s;
    assign m_en  = i_gnt_s | d_gnt_s;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed per-cycle vectors push expected
// grants and responses; a negedge monitor pops and compares them.
module tb_unified_mem_arbiter;

    localparam logic [1:0] G_N = 2'd0;
    localparam logic [1:0] G_I = 2'd1;
    localparam logic [1:0] G_D = 2'd2;
    localparam logic [31:0] PAT = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic [31:0] m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;

    unified_mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data one cycle after a read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (m_en && (m_we == 4'b0000)) m_rdata <= m_addr ^ PAT;
        else                           m_rdata <= 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        rst;
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic [3:0]  dwe;
        logic [31:0] dwd;
        logic [1:0]  eg;
        logic [31:0] ea;
        logic [3:0]  ewe;
        logic [31:0] ewd;
        logic [1:0]  ep;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [1:0]  g;
        logic [31:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
    } gexp_t;

    typedef struct {
        int          cyc;
        logic [1:0]  kind;
        logic [31:0] data;
    } rexp_t;

    vec_t  vecs[$];
    gexp_t gq[$];
    rexp_t rq[$];
    gexp_t gcur;
    rexp_t rcur;
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic [31:0] da, input logic [3:0] dwe,
                       input logic [31:0] dwd, input logic [1:0] eg, input logic [31:0] ea,
                       input logic [3:0] ewe, input logic [31:0] ewd, input logic [1:0] ep);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.dwe = dwe; v.dwd = dwd;
        v.eg = eg; v.ea = ea; v.ewe = ewe; v.ewd = ewd; v.ep = ep;
        vecs.push_back(v);
    endtask

    task automatic v_rst();
        add(1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 4'h0, 32'h55, G_N, 32'h0, 4'h0, 32'h0, G_N);
    endtask

    task automatic v_idle();
        add(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, G_N, 32'h0, 4'h0, 32'h0, G_N);
    endtask

    task automatic v_fetch(input logic [31:0] a, input logic [31:0] ea);
        add(1'b1, 1'b1, a, 1'b0, 32'h0, 4'h0, 32'h0, G_I, ea, 4'h0, 32'h0, G_I);
    endtask

    task automatic v_data(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                          input logic [31:0] ea, input logic [1:0] ep);
        add(1'b1, 1'b0, 32'h0, 1'b1, a, we, wd, G_D, ea, we, wd, ep);
    endtask

    // Both requesters high: fetch 0x502, data read 0x603 with nonzero wdata.
    task automatic v_both(input logic [1:0] g, input logic drop);
        if (g == G_I)
            add(1'b1, 1'b1, 32'h502, 1'b1, 32'h603, 4'h0, 32'h0BAD_F00D,
                G_I, 32'h500, 4'h0, 32'h0, drop ? G_N : G_I);
        else
            add(1'b1, 1'b1, 32'h502, 1'b1, 32'h603, 4'h0, 32'h0BAD_F00D,
                G_D, 32'h600, 4'h0, 32'h0BAD_F00D, drop ? G_N : G_D);
    endtask

    // Monitor: compare grants every cycle and responses whenever an rvalid appears.
    always @(negedge clk) begin
        if (gq.size() > 0 && gq[0].cyc == cyc) begin
            gcur = gq.pop_front();
            check("i_gnt",   {31'b0, i_gnt}, {31'b0, gcur.g == G_I});
            check("d_gnt",   {31'b0, d_gnt}, {31'b0, gcur.g == G_D});
            check("m_en",    {31'b0, m_en},  {31'b0, gcur.g != G_N});
            check("m_addr",  m_addr, gcur.a);
            check("m_we",    {28'b0, m_we}, {28'b0, gcur.we});
            check("m_wdata", m_wdata, gcur.wd);
        end
        if (cyc > 0) begin
            check("rvalid_excl", {31'b0, i_rvalid & d_rvalid}, 32'd0);
            if (!i_rvalid) check("i_rdata_idle", i_rdata, 32'd0);
            if (!d_rvalid) check("d_rdata_idle", d_rdata, 32'd0);
            if (i_rvalid || d_rvalid) begin
                if (rq.size() == 0) begin
                    check("resp_unexpected", {31'b0, i_rvalid | d_rvalid}, 32'd0);
                end else begin
                    rcur = rq.pop_front();
                    check("resp_kind", {30'b0, d_rvalid, i_rvalid}, {30'b0, rcur.kind});
                    check("resp_cycle", cyc, rcur.cyc);
                    check("resp_data", i_rvalid ? i_rdata : d_rdata, rcur.data);
                end
            end else if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                rcur = rq.pop_front();
                check("resp_missing", {31'b0, i_rvalid | d_rvalid}, 32'd1);
            end
        end
    end

    initial begin
        gexp_t g;
        rexp_t r;
        reset = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0;
        d_addr = 32'h0; d_we = 4'h0; d_wdata = 32'h0;

        v_rst(); v_rst();
        v_fetch(32'h103, 32'h100);
        v_idle();
        v_data(32'h20, 4'b1100, 32'hABCD_0000, 32'h20, G_N);
        v_idle();
        v_data(32'h47, 4'b0000, 32'h1234_5678, 32'h44, G_D);
        v_fetch(32'h200, 32'h200);
        v_data(32'h300, 4'b0000, 32'h0, 32'h300, G_D);
        v_fetch(32'h404, 32'h404);
        v_idle();
        // Contention: D,D,D,D,I twice.
        for (int k = 0; k < 10; k++) v_both((k % 5 == 4) ? G_I : G_D, 1'b0);
        v_idle();
        // Dropping i_req clears the streak mid-run.
        for (int k = 0; k < 3; k++) v_both(G_D, 1'b0);
        v_data(32'h64, 4'b0000, 32'h0, 32'h64, G_D);
        for (int k = 0; k < 5; k++) v_both((k == 4) ? G_I : G_D, 1'b0);
        // Reset right after a data-read grant with streak at 3.
        v_both(G_D, 1'b0); v_both(G_D, 1'b0); v_both(G_D, 1'b1);
        v_rst();
        for (int k = 0; k < 5; k++) v_both((k == 4) ? G_I : G_D, 1'b0);
        v_idle(); v_idle();

        foreach (vecs[k]) begin
            @(posedge clk);
            #1;
            reset = vecs[k].rst; i_req = vecs[k].ir; i_addr = vecs[k].ia;
            d_req = vecs[k].dr; d_addr = vecs[k].da; d_we = vecs[k].dwe; d_wdata = vecs[k].dwd;
            g.cyc = cyc; g.g = vecs[k].eg; g.a = vecs[k].ea; g.we = vecs[k].ewe; g.wd = vecs[k].ewd;
            gq.push_back(g);
            if (vecs[k].ep != G_N) begin
                r.cyc = cyc + 1; r.kind = vecs[k].ep; r.data = vecs[k].ea ^ PAT;
                rq.push_back(r);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("grant_queue_drained", gq.size(), 32'd0);
        check("resp_queue_drained", rq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
